// File: rtl/yarp_lsu.sv
// yarp_lsu: load/store unit between the execute stage and data memory.
// The memory port only ever carries whole aligned words; sub-word loads are
// extracted and extended here, sub-word stores are read-modify-write.
//
// Build macro: YARP_LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned accesses return err with no memory access
//   undefined -> misaligned accesses are force-aligned and proceed
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request, no memory activity
// RD    | read request on the memory port
// WAIT  | read word valid: extract for loads, merge for sub-word stores
// WR    | write request on the memory port with the final word
// RESP  | response valid, held until lsu_resp_ready_i
module yarp_lsu #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic        lsu_req_wr_i,
    input  logic [31:0] lsu_req_addr_i,
    input  logic [1:0]  lsu_req_size_i,
    input  logic        lsu_req_unsigned_i,
    input  logic [31:0] lsu_req_wdata_i,
    output logic        lsu_resp_valid_o,
    input  logic        lsu_resp_ready_i,
    output logic [31:0] lsu_resp_rdata_o,
    output logic        lsu_resp_err_o,
    output logic        lsu_busy_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [31:0] data_addr_o,
    output logic [1:0]  data_byte_en_o,
    output logic        data_zero_extnd_o,
    output logic [31:0] data_wr_data_o,
    input  logic [31:0] data_mem_rd_data_i
);

    localparam logic [1:0]  BYTE       = 2'b00;
    localparam logic [1:0]  HALF_WORD  = 2'b01;
    localparam logic [1:0]  WORD       = 2'b11;
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RESP
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_data_req;
    logic        r_data_wr;
    logic [31:0] r_data_addr;
    logic [31:0] r_data_wr_data;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_wr;
    logic        r_unsigned;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_req_half;
    logic        w_req_word;
    logic [31:0] w_eff_addr;
    logic        w_fault;
    logic [4:0]  w_shift;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept   = lsu_req_valid_i & r_req_ready;
    assign w_req_half = (lsu_req_size_i == HALF_WORD);
    // The unused encoding 2'b10 is handled as a full word
    assign w_req_word = (lsu_req_size_i != BYTE) && !w_req_half;

    // Effective address and fault decision for the request being offered
    always_comb begin
        w_eff_addr = lsu_req_addr_i;
        w_fault    = 1'b0;
`ifdef YARP_LSU_MISALIGN_TRAP_EN
        if ((w_req_half && lsu_req_addr_i[0]) ||
            (w_req_word && (lsu_req_addr_i[1:0] != 2'b00)))
            w_fault = 1'b1;
`else
        if (w_req_half)
            w_eff_addr[0] = 1'b0;
        else if (w_req_word)
            w_eff_addr[1:0] = 2'b00;
`endif
        if ((w_eff_addr - DMEM_BASE) >= DMEM_BYTES)
            w_fault = 1'b1;
    end

    // Lane extraction and sign/zero extension of the returned read word
    always_comb begin
        w_shift   = (r_size == HALF_WORD) ? {r_lane[1], 4'b0000} : {r_lane, 3'b000};
        w_shifted = data_mem_rd_data_i >> w_shift;
        case (r_size)
            BYTE:      w_load = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            HALF_WORD: w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load = data_mem_rd_data_i;
        endcase
    end

    // Merge of sub-word store data into the returned read word
    always_comb begin
        w_merged = data_mem_rd_data_i;
        if (r_size == BYTE)
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    // Sequencer with registered outputs; memory strobes default low so each
    // access is a single-cycle pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 32'h0;
            r_resp_err     <= 1'b0;
            r_data_req     <= 1'b0;
            r_data_wr      <= 1'b0;
            r_data_addr    <= 32'h0;
            r_data_wr_data <= 32'h0;
            r_lane         <= 2'b00;
            r_size         <= BYTE;
            r_wr           <= 1'b0;
            r_unsigned     <= 1'b0;
            r_wdata        <= 32'h0;
        end else begin
            r_data_req <= 1'b0;
            r_data_wr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_lane      <= w_eff_addr[1:0];
                        r_size      <= w_req_word ? WORD : lsu_req_size_i;
                        r_wr        <= lsu_req_wr_i;
                        r_unsigned  <= lsu_req_unsigned_i;
                        r_wdata     <= lsu_req_wdata_i;
                        r_data_addr <= {w_eff_addr[31:2], 2'b00};
                        if (w_fault) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else if (lsu_req_wr_i && w_req_word) begin
                            r_state        <= WR;
                            r_data_req     <= 1'b1;
                            r_data_wr      <= 1'b1;
                            r_data_wr_data <= lsu_req_wdata_i;
                        end else begin
                            r_state    <= RD;
                            r_data_req <= 1'b1;
                        end
                    end
                end
                RD: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_wr) begin
                        r_state        <= WR;
                        r_data_req     <= 1'b1;
                        r_data_wr      <= 1'b1;
                        r_data_wr_data <= w_merged;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load;
                    end
                end
                WR: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                end
                RESP: begin
                    if (lsu_resp_ready_i) begin
                        r_state      <= IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'h0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign lsu_req_ready_o   = r_req_ready;
    assign lsu_resp_valid_o  = r_resp_valid;
    assign lsu_resp_rdata_o  = r_resp_rdata;
    assign lsu_resp_err_o    = r_resp_err;
    assign lsu_busy_o        = (r_state != IDLE);
    assign data_req_o        = r_data_req;
    assign data_wr_o         = r_data_wr;
    assign data_addr_o       = r_data_addr;
    assign data_byte_en_o    = WORD;
    assign data_zero_extnd_o = 1'b0;
    assign data_wr_data_o    = r_data_wr_data;

endmodule
